fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage that sits directly upstream of `execute`. It holds the architectural PC, fetches from a multi-cycle instruction memory over a req/ready handshake, and presents `instr` and `next_pc` (PC+2) to decode/execute. It then waits for the retire pulse before loading the PC that `execute` computed. It also detects HALT and reports fetch errors.

## Interface
- `RESET_PC`, 16'h0000, PC value loaded on reset.
- `WAIT_MAX`, 8, max cycles in FETCH without `imem_ready` before timeout error (range 1..255).

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `new_pc`  in  16  PC produced by `execute` (branch/jump target or next_pc).
- `instr_done`  in  1  one-cycle pulse: current instruction retired, load `new_pc`.
- `imem_req`  out  1  fetch request, registered.
- `imem_addr`  out  16  fetch address (= PC register).
- `imem_rdata`  in  16  instruction word, valid when `imem_ready`.
- `imem_ready`  in  1  memory accepts and returns data this cycle.
- `instr`  out  16  captured instruction.
- `next_pc`  out  16  PC + 2, combinational from PC register.
- `instr_valid`  out  1  `instr` is valid for downstream.
- `halt`  out  1  sticky; HALT retired or error.
- `err`  out  1  sticky; timeout (or misalignment, see Configuration).

## Operation
- States: IDLE, FETCH, HOLD, HALTED.
- Reset values: state IDLE, PC=`RESET_PC`, `imem_req`=0, `instr`=16'h0800 (NOP), `instr_valid`=0, `halt`=0, `err`=0, wait counter=0. `next_pc` = `RESET_PC`+2.
- IDLE -> FETCH unconditionally on the first clock edge with `rst`=0.
- FETCH:
  - `imem_req`=1 and `imem_addr`=PC.
  - On `imem_ready`: `instr` <= `imem_rdata`, counter cleared, state goes to HOLD.
  - Otherwise the counter increments. When it reaches `WAIT_MAX`: `err`=1, `halt`=1, state goes to HALTED.
- HOLD:
  - `instr_valid`=1 and `imem_req`=0.
  - On `instr_done`:
    - If `instr[15:11]`==5'b00000 (HALT): `halt`=1, state goes to HALTED, PC unchanged.
    - Otherwise: PC <= `new_pc`, state goes to FETCH.
- HALTED: `imem_req`=0, `instr_valid`=0. Only `rst` leaves this state.
- Ignored inputs:
  - `instr_done` outside HOLD.
  - `imem_ready` outside FETCH.
  - `new_pc` except on the accepted `instr_done`.
- Arithmetic: PC+2 is modulo 2^16, so 16'hFFFE+2 = 16'h0000. No flag is raised.

## Timing
- The clock edge sampling `imem_ready`=1 in FETCH both captures `instr` and changes state to HOLD. `instr_valid` is high from the next cycle.
- Minimum fetch latency: 1 cycle of `imem_req` (ready on the first request cycle).
- `instr_done` in HOLD loads the PC at that edge. `imem_req` for the new PC rises the next cycle, so there is no bubble beyond one cycle.
- Ready and timeout in the same cycle: ready wins, no error.
- `rst` asserted in any state, including mid-FETCH: all registers return to reset values at that edge. Any outstanding request is abandoned, so memory must tolerate `imem_req` dropping.
- `imem_req`, `instr`, `instr_valid`, `halt` and `err` are all registered. Only `next_pc` is combinational.

## Configuration
- `FETCH_ALIGN_CHK_EN` defined:
  - On an accepted `instr_done` with `new_pc[0]`=1: `err`=1, `halt`=1, state goes to HALTED, and no request is issued.
  - Also checked on `RESET_PC` at IDLE->FETCH.
- Undefined: no check. `imem_addr` carries the PC verbatim, including bit 0.

## Structure
- Shared package `fetch_pkg`:
  - state enum (IDLE/FETCH/HOLD/HALTED);
  - `OP_HALT`=5'b00000;
  - `OP_NOP`=5'b00001;
  - `NOP_INSTR`=16'h0800;
  - `PC_INC`=16'h0002.
- One sub-module: existing `cla_16` instance computing `next_pc` = PC + `PC_INC` (Cin=0).

## Test plan
- Reset with `RESET_PC`=16'h0100, ready tied high:
  - cycle after release: `imem_req`=1, `imem_addr`=16'h0100;
  - next cycle: `instr_valid`=1, `next_pc`=16'h0102.
- Ready delayed 3 cycles, `imem_rdata`=16'h4123 → `imem_req` held 4 cycles, `instr`=16'h4123, then on `instr_done` with `new_pc`=16'h0200 → `imem_addr`=16'h0200.
- Ready never asserted, `WAIT_MAX`=8 → `err`=1 and `halt`=1 after 8 FETCH cycles, `imem_req`=0 thereafter.
- Fetch 16'h0000 (HALT) then `instr_done` → `halt`=1, `instr_valid`=0, no further requests until `rst`.
- PC=16'hFFFE → `next_pc`=16'h0000. With `FETCH_ALIGN_CHK_EN`, `new_pc`=16'h0203 → `err`=1, no request issued.
- `rst` pulsed mid-FETCH → outputs return to reset values at that edge, then fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StHold,
    StHalted
  } fetch_state_e;

  localparam logic [4:0]  OP_HALT   = 5'b00000;
  localparam logic [4:0]  OP_NOP    = 5'b00001;
  localparam logic [15:0] NOP_INSTR = {OP_NOP, 11'b0};
  localparam logic [15:0] PC_INC    = 16'h0002;

  function automatic logic is_halt(input logic [15:0] instr);
    return instr[15:11] == OP_HALT;
  endfunction

endpackage

// File: rtl/cla_16.sv
// 16-bit carry-lookahead adder: four 4-bit groups with a second-level group-carry lookahead.
module cla_16 (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  input  logic        i_cin,
  output logic [15:0] o_sum
);

  logic [15:0] w_p;
  logic [15:0] w_g;
  logic [2:0]  w_gp;
  logic [2:0]  w_gg;
  logic [3:0]  w_gc;
  logic [15:0] w_c;

  assign w_p = i_a ^ i_b;
  assign w_g = i_a & i_b;

  always_comb begin
    w_gp = '0;
    w_gg = '0;
    for (int k = 0; k < 3; k++) begin
      w_gp[k] = &w_p[4*k +: 4];
      w_gg[k] = w_g[4*k+3] | (w_p[4*k+3] & w_g[4*k+2])
              | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
              | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_g[4*k]);
    end
  end

  // Group carries are fully expanded so no carry ripples between groups.
  assign w_gc[0] = i_cin;
  assign w_gc[1] = w_gg[0] | (w_gp[0] & i_cin);
  assign w_gc[2] = w_gg[1] | (w_gp[1] & w_gg[0]) | (w_gp[1] & w_gp[0] & i_cin);
  assign w_gc[3] = w_gg[2] | (w_gp[2] & w_gg[1]) | (w_gp[2] & w_gp[1] & w_gg[0])
                 | (w_gp[2] & w_gp[1] & w_gp[0] & i_cin);

  always_comb begin
    w_c = '0;
    for (int k = 0; k < 4; k++) begin
      w_c[4*k]   = w_gc[k];
      w_c[4*k+1] = w_g[4*k] | (w_p[4*k] & w_gc[k]);
      w_c[4*k+2] = w_g[4*k+1] | (w_p[4*k+1] & w_g[4*k])
                 | (w_p[4*k+1] & w_p[4*k] & w_gc[k]);
      w_c[4*k+3] = w_g[4*k+2] | (w_p[4*k+2] & w_g[4*k+1])
                 | (w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
                 | (w_p[4*k+2] & w_p[4*k+1] & w_p[4*k] & w_gc[k]);
    end
  end

  assign o_sum = w_p ^ w_c;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over req/ready, holds until retire.
// Optional PC alignment check enabled by defining FETCH_ALIGN_CHK_EN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int unsigned WAIT_MAX = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_new_pc,
  input  logic        i_instr_done,
  output logic        o_imem_req,
  output logic [15:0] o_imem_addr,
  input  logic [15:0] i_imem_rdata,
  input  logic        i_imem_ready,
  output logic [15:0] o_instr,
  output logic [15:0] o_next_pc,
  output logic        o_instr_valid,
  output logic        o_halt,
  output logic        o_err
);

  localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

`ifdef FETCH_ALIGN_CHK_EN
  localparam logic RESET_PC_BAD = RESET_PC[0];
  logic w_new_pc_bad;
  assign w_new_pc_bad = i_new_pc[0];
`else
  localparam logic RESET_PC_BAD = 1'b0;
  logic w_new_pc_bad;
  assign w_new_pc_bad = 1'b0;
`endif

  fetch_state_e r_state;
  logic [15:0]  r_pc;
  logic         r_req;
  logic [15:0]  r_instr;
  logic         r_valid;
  logic         r_halt;
  logic         r_err;
  logic [7:0]   r_wait_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= StIdle;
      r_pc       <= RESET_PC;
      r_req      <= 1'b0;
      r_instr    <= NOP_INSTR;
      r_valid    <= 1'b0;
      r_halt     <= 1'b0;
      r_err      <= 1'b0;
      r_wait_cnt <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (RESET_PC_BAD) begin
            r_err   <= 1'b1;
            r_halt  <= 1'b1;
            r_state <= StHalted;
          end else begin
            r_req   <= 1'b1;
            r_state <= StFetch;
          end
        end
        StFetch: begin
          // Ready takes priority over a timeout in the same cycle.
          if (i_imem_ready) begin
            r_instr    <= i_imem_rdata;
            r_wait_cnt <= '0;
            r_req      <= 1'b0;
            r_valid    <= 1'b1;
            r_state    <= StHold;
          end else if (r_wait_cnt == WAIT_LAST) begin
            r_err   <= 1'b1;
            r_halt  <= 1'b1;
            r_req   <= 1'b0;
            r_state <= StHalted;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end
        StHold: begin
          if (i_instr_done) begin
            r_valid <= 1'b0;
            if (is_halt(r_instr)) begin
              r_halt  <= 1'b1;
              r_state <= StHalted;
            end else if (w_new_pc_bad) begin
              r_err   <= 1'b1;
              r_halt  <= 1'b1;
              r_state <= StHalted;
            end else begin
              r_pc    <= i_new_pc;
              r_req   <= 1'b1;
              r_state <= StFetch;
            end
          end
        end
        StHalted: begin
          r_req   <= 1'b0;
          r_valid <= 1'b0;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  cla_16 u_pc_inc (
    .i_a   (r_pc),
    .i_b   (PC_INC),
    .i_cin (1'b0),
    .o_sum (o_next_pc)
  );

  assign o_imem_req    = r_req;
  assign o_imem_addr   = r_pc;
  assign o_instr       = r_instr;
  assign o_instr_valid = r_valid;
  assign o_halt        = r_halt;
  assign o_err         = r_err;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit with expected-address and expected-instruction scoreboards.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic [15:0] new_pc;
  logic        instr_done;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_ready;
  logic [15:0] instr;
  logic [15:0] next_pc;
  logic        instr_valid;
  logic        halt;
  logic        err;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_addr_q[$];
  logic [15:0] exp_instr_q[$];

  fetch_unit #(
    .RESET_PC (16'h0100),
    .WAIT_MAX (8)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_new_pc      (new_pc),
    .i_instr_done  (instr_done),
    .o_imem_req    (imem_req),
    .o_imem_addr   (imem_addr),
    .i_imem_rdata  (imem_rdata),
    .i_imem_ready  (imem_ready),
    .o_instr       (instr),
    .o_next_pc     (next_pc),
    .o_instr_valid (instr_valid),
    .o_halt        (halt),
    .o_err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  // Reset, release, and land on the first FETCH cycle (expected address queued).
  task automatic start();
    rst = 1'b1; instr_done = 1'b0; imem_ready = 1'b0;
    step();
    rst = 1'b0;
    exp_addr_q.push_back(16'h0100);
    step();
  endtask

  // Memory model: answer the outstanding request on its lat-th cycle.
  task automatic fetch_word(input int lat, input logic [15:0] data, output int nreq);
    nreq = 0;
    exp_instr_q.push_back(data);
    for (int i = 0; i < 40; i++) begin
      if (!imem_req) break;
      nreq++;
      imem_rdata = data;
      imem_ready = (nreq >= lat);
      step();
    end
    imem_ready = 1'b0;
  endtask

  task automatic retire(input logic [15:0] pc);
    exp_addr_q.push_back(pc);
    instr_done = 1'b1; new_pc = pc;
    step();
    instr_done = 1'b0; new_pc = 16'hDEAD;
  endtask

  task automatic test_reset();
    logic [15:0] e;
    rst = 1'b1; instr_done = 1'b0; imem_ready = 1'b0; new_pc = 16'h0; imem_rdata = 16'h0;
    step(); step();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %h want 0", imem_req); end
    checks++; if (imem_addr !== 16'h0100) begin errors++; $display("FAIL reset_addr: got %h want 0100", imem_addr); end
    checks++; if (instr !== 16'h0800) begin errors++; $display("FAIL reset_instr: got %h want 0800", instr); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %h want 0", instr_valid); end
    checks++; if (halt !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_flags: got halt=%h err=%h want 0 0", halt, err); end
    checks++; if (next_pc !== 16'h0102) begin errors++; $display("FAIL reset_next_pc: got %h want 0102", next_pc); end
    // Release with ready tied high.
    rst = 1'b0; imem_ready = 1'b1; imem_rdata = 16'h1234;
    exp_addr_q.push_back(16'h0100); exp_instr_q.push_back(16'h1234);
    step();
    e = exp_addr_q.pop_front();
    checks++; if (imem_req !== 1'b1 || imem_addr !== e) begin errors++; $display("FAIL first_req: got req=%h addr=%h want 1 %h", imem_req, imem_addr, e); end
    step();
    e = exp_instr_q.pop_front();
    checks++; if (instr_valid !== 1'b1 || instr !== e) begin errors++; $display("FAIL first_instr: got v=%h instr=%h want 1 %h", instr_valid, instr, e); end
    checks++; if (imem_req !== 1'b0 || next_pc !== 16'h0102) begin errors++; $display("FAIL first_hold: got req=%h next_pc=%h want 0 0102", imem_req, next_pc); end
    imem_ready = 1'b0;
  endtask

  task automatic test_delayed_ready();
    logic [15:0] e;
    int n;
    retire(16'h0200);
    e = exp_addr_q.pop_front();
    checks++; if (imem_req !== 1'b1 || imem_addr !== e) begin errors++; $display("FAIL delayed_addr: got req=%h addr=%h want 1 %h", imem_req, imem_addr, e); end
    fetch_word(4, 16'h4123, n);
    checks++; if (n !== 4) begin errors++; $display("FAIL delayed_req_cycles: got %0d want 4", n); end
    e = exp_instr_q.pop_front();
    checks++; if (instr_valid !== 1'b1 || instr !== e) begin errors++; $display("FAIL delayed_instr: got v=%h instr=%h want 1 %h", instr_valid, instr, e); end
  endtask

  task automatic test_timeout();
    logic [15:0] e;
    int n = 0;
    start();
    e = exp_addr_q.pop_front();
    checks++; if (imem_addr !== e) begin errors++; $display("FAIL timeout_addr: got %h want %h", imem_addr, e); end
    for (int i = 0; i < 30; i++) begin
      if (halt) break;
      if (imem_req) n++;
      step();
    end
    checks++; if (n !== 8) begin errors++; $display("FAIL timeout_cycles: got %0d want 8", n); end
    checks++; if (err !== 1'b1 || halt !== 1'b1) begin errors++; $display("FAIL timeout_flags: got err=%h halt=%h want 1 1", err, halt); end
    for (int i = 0; i < 3; i++) begin
      imem_ready = 1'b1;
      step();
      checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("FAIL timeout_quiet: got req=%h v=%h want 0 0", imem_req, instr_valid); end
    end
    imem_ready = 1'b0;
  endtask

  task automatic test_ready_vs_timeout();
    logic [15:0] e;
    int n;
    start();
    void'(exp_addr_q.pop_front());
    fetch_word(8, 16'h2345, n);
    e = exp_instr_q.pop_front();
    checks++; if (n !== 8 || err !== 1'b0) begin errors++; $display("FAIL ready_wins: got n=%0d err=%h want 8 0", n, err); end
    checks++; if (instr_valid !== 1'b1 || instr !== e) begin errors++; $display("FAIL ready_wins_instr: got v=%h instr=%h want 1 %h", instr_valid, instr, e); end
    retire(16'h0120);
    e = exp_addr_q.pop_front();
    checks++; if (imem_addr !== e) begin errors++; $display("FAIL rvt_addr: got %h want %h", imem_addr, e); end
    fetch_word(8, 16'h2468, n);
    e = exp_instr_q.pop_front();
    checks++; if (err !== 1'b0 || instr_valid !== 1'b1 || instr !== e) begin errors++; $display("FAIL counter_cleared: got err=%h v=%h instr=%h want 0 1 %h", err, instr_valid, instr, e); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] e;
    logic [15:0] pc;
    logic [15:0] data;
    int n;
    start();
    pc = 16'h0100;
    e = exp_addr_q.pop_front();
    checks++; if (imem_addr !== e) begin errors++; $display("FAIL b2b_first_addr: got %h want %h", imem_addr, e); end
    for (int k = 0; k < 4; k++) begin
      if (k == 1) begin
        // Retire pulse while fetching must be ignored.
        instr_done = 1'b1; new_pc = 16'h5550;
        step();
        instr_done = 1'b0;
        checks++; if (imem_addr !== pc || imem_req !== 1'b1) begin errors++; $display("FAIL b2b_done_in_fetch: got addr=%h req=%h want %h 1", imem_addr, imem_req, pc); end
      end
      data = {5'(k + 2), 11'($urandom)};
      fetch_word(k + 1, data, n);
      e = exp_instr_q.pop_front();
      checks++; if (n !== k + 1 || instr !== e) begin errors++; $display("FAIL b2b_instr%0d: got n=%0d instr=%h want %0d %h", k, n, instr, k + 1, e); end
      checks++; if (next_pc !== pc + 16'd2) begin errors++; $display("FAIL b2b_next_pc%0d: got %h want %h", k, next_pc, pc + 16'd2); end
      if (k == 2) begin
        // Ready while holding must not overwrite the captured word.
        imem_ready = 1'b1; imem_rdata = 16'hFFFF;
        step();
        imem_ready = 1'b0;
        checks++; if (instr !== e) begin errors++; $display("FAIL b2b_ready_in_hold: got %h want %h", instr, e); end
      end
      pc = pc + 16'h0010;
      retire(pc);
      e = exp_addr_q.pop_front();
      checks++; if (imem_req !== 1'b1 || imem_addr !== e) begin errors++; $display("FAIL b2b_addr%0d: got req=%h addr=%h want 1 %h", k, imem_req, imem_addr, e); end
    end
  endtask

  task automatic test_halt();
    logic [15:0] e;
    int n;
    start();
    void'(exp_addr_q.pop_front());
    fetch_word(1, 16'h0123, n);
    e = exp_instr_q.pop_front();
    checks++; if (instr !== e) begin errors++; $display("FAIL halt_instr: got %h want %h", instr, e); end
    instr_done = 1'b1; new_pc = 16'h0400;
    step();
    instr_done = 1'b0;
    checks++; if (halt !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL halt_flags: got halt=%h err=%h want 1 0", halt, err); end
    checks++; if (instr_valid !== 1'b0 || imem_addr !== 16'h0100) begin errors++; $display("FAIL halt_state: got v=%h addr=%h want 0 0100", instr_valid, imem_addr); end
    for (int i = 0; i < 4; i++) begin
      imem_ready = 1'b1; instr_done = 1'b1; new_pc = 16'h0500;
      step();
      checks++; if (imem_req !== 1'b0 || halt !== 1'b1) begin errors++; $display("FAIL halt_sticky: got req=%h halt=%h want 0 1", imem_req, halt); end
    end
    imem_ready = 1'b0; instr_done = 1'b0;
    start();
    e = exp_addr_q.pop_front();
    checks++; if (halt !== 1'b0 || imem_req !== 1'b1 || imem_addr !== e) begin errors++; $display("FAIL halt_recover: got halt=%h req=%h addr=%h want 0 1 %h", halt, imem_req, imem_addr, e); end
  endtask

  task automatic test_wrap_align();
    logic [15:0] e;
    int n;
    fetch_word(1, 16'h0801, n);
    void'(exp_instr_q.pop_front());
    retire(16'hFFFE);
    e = exp_addr_q.pop_front();
    checks++; if (imem_addr !== e) begin errors++; $display("FAIL wrap_addr: got %h want %h", imem_addr, e); end
    checks++; if (next_pc !== 16'h0000) begin errors++; $display("FAIL wrap_next_pc: got %h want 0000", next_pc); end
    fetch_word(2, 16'h0802, n);
    e = exp_instr_q.pop_front();
    checks++; if (instr !== e || err !== 1'b0) begin errors++; $display("FAIL wrap_instr: got %h err=%h want %h 0", instr, err, e); end
`ifdef FETCH_ALIGN_CHK_EN
    instr_done = 1'b1; new_pc = 16'h0203;
    step();
    instr_done = 1'b0;
    checks++; if (err !== 1'b1 || halt !== 1'b1 || imem_req !== 1'b0) begin errors++; $display("FAIL align_err: got err=%h halt=%h req=%h want 1 1 0", err, halt, imem_req); end
    step();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL align_no_req: got %h want 0", imem_req); end
`else
    retire(16'h0203);
    e = exp_addr_q.pop_front();
    checks++; if (imem_req !== 1'b1 || imem_addr !== e || err !== 1'b0) begin errors++; $display("FAIL odd_addr: got req=%h addr=%h err=%h want 1 %h 0", imem_req, imem_addr, err, e); end
`endif
  endtask

  task automatic test_reset_mid_fetch();
    logic [15:0] e;
    int n;
    start();
    void'(exp_addr_q.pop_front());
    fetch_word(1, 16'h5A5A, n);
    void'(exp_instr_q.pop_front());
    retire(16'h0300);
    e = exp_addr_q.pop_front();
    checks++; if (imem_addr !== e) begin errors++; $display("FAIL mid_addr: got %h want %h", imem_addr, e); end
    step(); step();
    rst = 1'b1;
    step();
    checks++; if (imem_req !== 1'b0 || imem_addr !== 16'h0100) begin errors++; $display("FAIL mid_rst_req: got req=%h addr=%h want 0 0100", imem_req, imem_addr); end
    checks++; if (instr !== 16'h0800 || instr_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_instr: got %h v=%h want 0800 0", instr, instr_valid); end
    checks++; if (halt !== 1'b0 || err !== 1'b0 || next_pc !== 16'h0102) begin errors++; $display("FAIL mid_rst_misc: got halt=%h err=%h next=%h want 0 0 0102", halt, err, next_pc); end
    rst = 1'b0;
    exp_addr_q.push_back(16'h0100);
    step();
    e = exp_addr_q.pop_front();
    checks++; if (imem_req !== 1'b1 || imem_addr !== e) begin errors++; $display("FAIL mid_restart: got req=%h addr=%h want 1 %h", imem_req, imem_addr, e); end
    fetch_word(1, 16'h1111, n);
    e = exp_instr_q.pop_front();
    checks++; if (instr_valid !== 1'b1 || instr !== e) begin errors++; $display("FAIL mid_refetch: got v=%h instr=%h want 1 %h", instr_valid, instr, e); end
  endtask

  initial begin
    rst = 1'b1; new_pc = 16'h0; instr_done = 1'b0; imem_rdata = 16'h0; imem_ready = 1'b0;
    test_reset();
    test_delayed_ready();
    test_timeout();
    test_ready_vs_timeout();
    test_back_to_back();
    test_halt();
    test_wrap_align();
    test_reset_mid_fetch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
